// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// Frame: 1 start, DATA_BITS data (LSB first), 1 stop.
package uart_pkg;

  localparam int UART_CLK_DIV_SIM  = 10;
  localparam int UART_CLK_DIV_9600 = 651;
  localparam int UART_OVERSAMPLE   = 16;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Free-running oversample tick: one-clk registered pulse
// every CLK_DIV clocks.
module uart_rx_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV_SIM
) (
  input  logic clk,
  input  logic reset,
  output logic br_tick
);

  localparam int CW = cnt_w(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    tick_d = 1'b0;
    if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign br_tick = tick_q;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling 8N1 UART receiver with framing-error flag.
// Bytes are delivered with a one-cycle rx_done strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = UART_CLK_DIV_SIM,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 frame_err
);

  localparam int TW = cnt_w(OVERSAMPLE);
  localparam int BW = cnt_w(DATA_BITS);

  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_END = BW'(DATA_BITS - 1);

  logic br_tick;

  logic rx_meta_q, rx_s_q, rx_prev_q;

  rx_state_e state_q, state_d;

  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 ferr_q, ferr_d;
  logic                 fall;

  uart_rx_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .br_tick (br_tick)
  );

  // Sync flops idle high so reset release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign fall = rx_prev_q & ~rx_s_q;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    ferr_d     = ferr_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d    = START;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end

      START: begin
        if (br_tick) begin
          if (tick_cnt_q == T_MID) begin
            tick_cnt_d = '0;
            state_d    = rx_s_q ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end

      DATA: begin
        if (br_tick) begin
          if (tick_cnt_q == T_END) begin
            shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            if (bit_cnt_q == B_END) begin
              state_d = STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end

      STOP: begin
        if (br_tick) begin
          if (tick_cnt_q == T_END) begin
            data_d     = shift_q;
            ferr_d     = ~rx_s_q;
            done_d     = 1'b1;
            tick_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ferr_q     <= ferr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_done   = done_q;
  assign rx_busy   = busy_q;
  assign frame_err = ferr_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the downstream stage of the existing UART transmitter.
- Consumes the serial `tx` line of the transmitter (board loopback or external), oversamples it 16x, and recovers 8N1 bytes.
- Presents each byte with a one-cycle `rx_done` strobe and a framing-error flag, for a FIFO or command decoder.

Parameters:
- CLK_DIV, 10, clk cycles per oversample tick. 10 matches the simulation build; 651 gives 9600 bps at 100 MHz.
- OVERSAMPLE, 16, ticks per bit. Must be even and ≥4.
- DATA_BITS, 8, data bits per frame, LSB first.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
- rx  input  1  asynchronous serial line, idle high
- rx_data  output  DATA_BITS  last received byte, held until next frame completes
- rx_done  output  1  one-cycle pulse when rx_data/frame_err are updated
- rx_busy  output  1  high while a frame is in progress (START/DATA/STOP)
- frame_err  output  1  stop bit sampled low on last frame; valid with/after rx_done

Behaviour:
- Reset (reset==0 at posedge): rx_data=0, rx_done=0, rx_busy=0, frame_err=0, state=IDLE, all counters=0, sync flops and edge flop=1.
- Input conditioning: 2-flop synchronizer rx→rx_s; rx_prev holds rx_s delayed one cycle.
- Tick generator:
  - Free-running counter 0..CLK_DIV-1.
  - br_tick is registered, high for one clk when the counter wraps (period CLK_DIV).
  - Not re-phased on start; ±1 tick phase error is accepted.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - rx_busy=0.
  - Falling edge (rx_prev==1 && rx_s==0) → START, tick_cnt=0, bit_cnt=0.
  - A held-low line (break) does not retrigger; a falling edge is required.
- START (on br_tick):
  - If tick_cnt==OVERSAMPLE/2-1, sample rx_s (mid start bit).
    - 0 → DATA, tick_cnt=0.
    - 1 → IDLE (glitch reject, no rx_done).
  - Otherwise tick_cnt++.
- DATA (on br_tick):
  - If tick_cnt==OVERSAMPLE-1: shift_reg={rx_s, shift_reg[DATA_BITS-1:1]}, tick_cnt=0.
    - bit_cnt==DATA_BITS-1 → STOP.
    - Otherwise bit_cnt++.
  - Otherwise tick_cnt++.
- STOP (on br_tick):
  - If tick_cnt==OVERSAMPLE-1: rx_data<=shift_reg, frame_err<=~rx_s, rx_done<=1 for exactly one clk, → IDLE.
  - Data is delivered even on a framing error.
- rx_busy=1 in START/DATA/STOP. Registered: it goes high the cycle after the falling edge is detected and low the same cycle rx_done goes high.
- Latency:
  - rx_done rises between 9.5·B+2 and 9.5·B+CLK_DIV+4 clk after the rx falling edge, where B=CLK_DIV·OVERSAMPLE.
  - With defaults: 1522..1534.
- Back-to-back frames: a new start edge is accepted on the first IDLE cycle.
  - The stop bit is sampled at mid-bit, so the next start edge arriving ≥½ bit later is caught.
- Reset mid-frame: the frame is abandoned, no rx_done, and all outputs go to reset values. The next full frame after reset release is received correctly.
- rx_data and frame_err never change except in the rx_done cycle.

Decomposition:
- Package uart_pkg:
  - rx_state_e enum {IDLE, START, DATA, STOP}.
  - Default constants: UART_CLK_DIV_SIM=10, UART_CLK_DIV_9600=651, UART_OVERSAMPLE=16.
- One sub-module, uart_rx_tick_gen: CLK_DIV counter → br_tick, same reset convention.
- Synchronizer and FSM live in uart_rx.

Test Plan:
- Loopback from the existing transmitter (same CLK_DIV=10) sending 0xA5 → exactly one rx_done pulse; rx_data=0xA5, frame_err=0; rx_busy low afterwards.
- Back-to-back transmissions 0x00, 0xFF, 0x55 with start asserted on the transmitter's tx_done → three rx_done pulses in order; rx_data=0x00, 0xFF, 0x55; no frame_err.
- Glitch: rx driven low for 40 clk (< half bit = 80 clk), then high → no rx_done, rx_busy returns to 0 within 90 clk; rx_data unchanged.
- Framing error: bench drives 0x3C with the stop bit low, then rx stays low 3 bit times, then high → one rx_done with rx_data=0x3C, frame_err=1. No second rx_done until a new falling edge; the next good frame 0x81 clears frame_err.
- Reset mid-frame: reset=0 for 2 clk during DATA bit 4 of 0xF0 → rx_busy=0, rx_done=0, rx_data=0. A subsequent 0x96 frame is received with rx_data=0x96.
- Baud tolerance: bench bit period 160±4 clk (±2.5%) for 0x6B → rx_data=0x6B, frame_err=0.
